// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with debounced inc/dec/clear keys, parallel load,
// wrap/saturate limits, over/underflow pulses and packed 8-digit display codes.

module bcd_debounce #(
  parameter int DEB_DELAY = 1000000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic key_i,
  output logic press_o
);
  localparam int CW = (DEB_DELAY > 1) ? $clog2(DEB_DELAY) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable, stable_q;

  // press_o compares stable against its own delayed copy, so it rises one
  // cycle after stable does and lasts exactly one cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      sync     <= {sync[0], key_i};
      stable_q <= stable;
      press_o  <= stable & ~stable_q;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_DELAY - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module bcd_updown_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int DEB_DELAY  = 1000000,
  parameter int WRAP       = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    inc_key_i,
  input  logic                    dec_key_i,
  input  logic                    clr_key_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_val_i,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    ovf_o,
  output logic                    unf_o,
  output logic [47:0]             dspl_o
);
  logic [2:0] key_raw, press;
  logic       inc_ev, dec_ev, clr_ev;

  logic [NUM_DIGITS-1:0][3:0] cnt_q, inc_val, dec_val, ld_val;
  logic all9, all0;

  assign key_raw = {clr_key_i, dec_key_i, inc_key_i};

  bcd_debounce #(.DEB_DELAY(DEB_DELAY)) u_deb [2:0] (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .key_i   (key_raw),
    .press_o (press)
  );

  assign inc_ev = press[0];
  assign dec_ev = press[1];
  assign clr_ev = press[2];

  // ripple carry/borrow across all digits in a single cycle
  always_comb begin
    logic cy, bw;
    cy   = 1'b1;
    bw   = 1'b1;
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc_val[i] = cnt_q[i];
      dec_val[i] = cnt_q[i];
      if (cy) begin
        if (cnt_q[i] == 4'd9) inc_val[i] = 4'd0;
        else begin
          inc_val[i] = cnt_q[i] + 4'd1;
          cy         = 1'b0;
        end
      end
      if (bw) begin
        if (cnt_q[i] == 4'd0) dec_val[i] = 4'd9;
        else begin
          dec_val[i] = cnt_q[i] - 4'd1;
          bw         = 1'b0;
        end
      end
      if (cnt_q[i] != 4'd9) all9 = 1'b0;
      if (cnt_q[i] != 4'd0) all0 = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_clamp
    assign ld_val[i] = (load_val_i[4*i+3:4*i] > 4'd9) ? 4'd9 : load_val_i[4*i+3:4*i];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
      if (clr_ev) begin
        cnt_q <= '0;
      end else if (load_i) begin
        cnt_q <= ld_val;
      end else if (inc_ev && dec_ev) begin
        cnt_q <= cnt_q;
      end else if (inc_ev) begin
        ovf_o <= all9;
        if (!all9 || WRAP != 0) cnt_q <= inc_val;
      end else if (dec_ev) begin
        unf_o <= all0;
        if (!all0 || WRAP != 0) cnt_q <= dec_val;
      end
    end
  end

  assign count_o = cnt_q;

  // digit k is lit when it is the LSD, blanking is off, or any digit at/above k is nonzero
  for (genvar k = 0; k < 8; k++) begin : g_dspl
    if (k < NUM_DIGITS) begin : g_on
      logic en;
      assign en = (k == 0) || (BLANK_LZ == 0) || (|count_o[4*NUM_DIGITS-1:4*k]);
      assign dspl_o[6*k+5:6*k] = {en, cnt_q[k], 1'b1};
    end else begin : g_off
      assign dspl_o[6*k+5:6*k] = 6'b000000;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: a wrapping and a saturating counter share all inputs and are
// checked against hand-computed counts, display codes and flag pulses.

module tb_bcd_updown_counter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inc_key = 1'b0, dec_key = 1'b0, clr_key = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count_w, count_s;
  logic        ovf_w, unf_w, ovf_s, unf_s;
  logic [47:0] dspl_w, dspl_s;

  int checks = 0, errors = 0;
  int ow = 0, uw = 0, os = 0, us = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(4), .DEB_DELAY(4), .WRAP(1), .BLANK_LZ(1)) dut (
    .clk_i(clk), .rstn_i(rstn), .inc_key_i(inc_key), .dec_key_i(dec_key),
    .clr_key_i(clr_key), .load_i(load), .load_val_i(load_val),
    .count_o(count_w), .ovf_o(ovf_w), .unf_o(unf_w), .dspl_o(dspl_w)
  );

  bcd_updown_counter #(.NUM_DIGITS(4), .DEB_DELAY(4), .WRAP(0), .BLANK_LZ(1)) dut_sat (
    .clk_i(clk), .rstn_i(rstn), .inc_key_i(inc_key), .dec_key_i(dec_key),
    .clr_key_i(clr_key), .load_i(load), .load_val_i(load_val),
    .count_o(count_s), .ovf_o(ovf_s), .unf_o(unf_s), .dspl_o(dspl_s)
  );

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    int          key;   // 0 none, 1 inc, 2 dec, 3 clr
    logic [15:0] exp_w;
    logic [15:0] exp_s;
    logic [47:0] exp_d;
    int          ovw, unw, ovs, uns;
  } vec_t;

  vec_t vt[12];

  function automatic logic [47:0] mk(logic [5:0] d4, logic [5:0] d3, logic [5:0] d2, logic [5:0] d1);
    return {24'd0, d4, d3, d2, d1};
  endfunction

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // one clock, inputs/outputs handled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    ow += int'(ovf_w); uw += int'(unf_w);
    os += int'(ovf_s); us += int'(unf_s);
  endtask

  task automatic press(int key, int hold);
    inc_key = (key == 1);
    dec_key = (key == 2);
    clr_key = (key == 3);
    repeat (hold) step();
    inc_key = 1'b0; dec_key = 1'b0; clr_key = 1'b0;
    repeat (10) step();
  endtask

  task automatic do_load(logic [15:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 16'h0000, 1, 16'h0001, 16'h0001, mk(6'h01,6'h01,6'h01,6'h23), 0,0,0,0};
    vt[1]  = '{1'b1, 16'h0099, 0, 16'h0099, 16'h0099, mk(6'h01,6'h01,6'h33,6'h33), 0,0,0,0};
    vt[2]  = '{1'b0, 16'h0000, 1, 16'h0100, 16'h0100, mk(6'h01,6'h23,6'h21,6'h21), 0,0,0,0};
    vt[3]  = '{1'b1, 16'h12F4, 0, 16'h1294, 16'h1294, mk(6'h23,6'h25,6'h33,6'h29), 0,0,0,0};
    vt[4]  = '{1'b0, 16'h0000, 2, 16'h1293, 16'h1293, mk(6'h23,6'h25,6'h33,6'h27), 0,0,0,0};
    vt[5]  = '{1'b1, 16'h9999, 0, 16'h9999, 16'h9999, mk(6'h33,6'h33,6'h33,6'h33), 0,0,0,0};
    vt[6]  = '{1'b0, 16'h0000, 1, 16'h0000, 16'h9999, mk(6'h01,6'h01,6'h01,6'h21), 1,0,1,0};
    vt[7]  = '{1'b0, 16'h0000, 2, 16'h9999, 16'h9998, mk(6'h33,6'h33,6'h33,6'h33), 0,1,0,0};
    vt[8]  = '{1'b0, 16'h0000, 3, 16'h0000, 16'h0000, mk(6'h01,6'h01,6'h01,6'h21), 0,0,0,0};
    vt[9]  = '{1'b0, 16'h0000, 2, 16'h9999, 16'h0000, mk(6'h33,6'h33,6'h33,6'h33), 0,1,0,1};
    vt[10] = '{1'b1, 16'h0999, 1, 16'h1000, 16'h1000, mk(6'h23,6'h21,6'h21,6'h21), 0,0,0,0};
    vt[11] = '{1'b0, 16'h0000, 2, 16'h0999, 16'h0999, mk(6'h01,6'h33,6'h33,6'h33), 0,0,0,0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset count", 48'(count_w), 48'h0);
    chk("reset flags", 48'({ovf_w, unf_w, ovf_s, unf_s}), 48'h0);
    chk("reset dspl", dspl_w, mk(6'h01,6'h01,6'h01,6'h21));
    rstn = 1'b1;
    step();

    // held key: count changes exactly at the 7th edge after first sampling
    inc_key = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 6) chk("inc latency pre", 48'(count_w), 48'h0);
      if (c == 7) chk("inc latency at", 48'(count_w), 48'h1);
      if (c == 9) chk("inc single event", 48'(count_w), 48'h1);
    end
    inc_key = 1'b0;
    repeat (10) step();

    // 2-cycle bounces never reach the debounce threshold
    for (int b = 0; b < 5; b++) begin
      inc_key = 1'b1; step(); step();
      inc_key = 1'b0; step(); step();
    end
    repeat (12) step();
    chk("bounce ignored", 48'(count_w), 48'h1);

    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();

    for (int i = 0; i < 12; i++) begin
      ow = 0; uw = 0; os = 0; us = 0;
      if (vt[i].ld) do_load(vt[i].lv);
      if (vt[i].key != 0) press(vt[i].key, 8);
      chk($sformatf("v%0d count_w", i), 48'(count_w), 48'(vt[i].exp_w));
      chk($sformatf("v%0d count_s", i), 48'(count_s), 48'(vt[i].exp_s));
      chk($sformatf("v%0d dspl_w", i), dspl_w, vt[i].exp_d);
      chk($sformatf("v%0d ovf_w", i), 48'(ow), 48'(vt[i].ovw));
      chk($sformatf("v%0d unf_w", i), 48'(uw), 48'(vt[i].unw));
      chk($sformatf("v%0d ovf_s", i), 48'(os), 48'(vt[i].ovs));
      chk($sformatf("v%0d unf_s", i), 48'(us), 48'(vt[i].uns));
    end

    // coincident inc and dec events cancel
    ow = 0; uw = 0; os = 0; us = 0;
    inc_key = 1'b1; dec_key = 1'b1;
    repeat (8) step();
    inc_key = 1'b0; dec_key = 1'b0;
    repeat (10) step();
    chk("inc+dec count", 48'(count_w), 48'h0999);
    chk("inc+dec flags", 48'(ow + uw + os + us), 48'h0);

    // ovf pulse lines up with the wrapped count
    do_load(16'h9999);
    inc_key = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      if (c == 6) chk("ovf before", 48'({ovf_w, ovf_s}), 48'h0);
      if (c == 7) chk("ovf at wrap", 48'({ovf_w, ovf_s, count_w}), {30'd0, 2'b11, 16'h0000});
      if (c == 8) chk("ovf width", 48'({ovf_w, ovf_s}), 48'h0);
    end
    inc_key = 1'b0;
    repeat (10) step();

    // clr event and load strobe in the same cycle: clear wins
    clr_key = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      load = 1'b0;
      if (c == 6) begin load = 1'b1; load_val = 16'h5555; end
      if (c == 7) chk("clr over load", 48'({count_w, count_s}), 48'h0);
    end
    clr_key = 1'b0;
    repeat (10) step();

    // async reset mid-debounce with a nonzero count, key still held after release
    do_load(16'h0042);
    inc_key = 1'b1;
    repeat (3) step();
    #2 rstn = 1'b0;
    #1;
    chk("async rst count", 48'({count_w, count_s}), 48'h0);
    chk("async rst dspl", dspl_w, mk(6'h01,6'h01,6'h01,6'h21));
    repeat (2) step();
    rstn = 1'b1;
    repeat (20) step();
    chk("held through reset", 48'(count_w), 48'h0001);
    inc_key = 1'b0;
    repeat (10) step();
    chk("no release event", 48'(count_w), 48'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
